// File: rtl/axi_ram_rd_arbiter.sv
// Round-robin arbiter sharing the AXI4 read channel of one RAM slave among PORTS
// burst requesters; one INCR burst outstanding, R beats routed to the granted port.
module axi_ram_rd_arbiter #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [PORTS-1:0]        req_valid,
  output logic [PORTS-1:0]        req_ready,
  input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*8-1:0]      req_len,

  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [PORTS-1:0]        rsp_valid,
  input  logic [PORTS-1:0]        rsp_ready,
  output logic                    rsp_last,
  output logic                    rsp_err,
  output logic                    proto_err,

  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int GW = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              count;
  logic                    arvalid_q;
  logic                    proto_q;

  logic [GW-1:0]           win;
  logic [GW-1:0]           cand;
  logic                    found;
  logic                    beat;

  // Search starts one past the previous winner so every port gets a turn.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    win   = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = GW'((int'(last_grant) + i) % PORTS);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[win] = 1'b1;
  end

  // The data path is pure wiring to the granted port: no added latency.
  always_comb begin
    rsp_valid = '0;
    if (state == DATA) rsp_valid[grant] = m_axi_rvalid;
  end

  assign m_axi_rready  = (state == DATA) && rsp_ready[grant];
  assign beat          = m_axi_rvalid && m_axi_rready;
  assign rsp_data      = m_axi_rdata;
  assign rsp_err       = (m_axi_rresp != 2'b00);
  assign rsp_last      = (count == 8'd0);
  assign proto_err     = proto_q;

  assign m_axi_arid    = ID_WIDTH'(grant);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;

  // Responses carry no routing information we need; the burst owner is in grant.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(PORTS - 1);
      addr_q     <= '0;
      len_q      <= '0;
      count      <= '0;
      arvalid_q  <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= win;
            addr_q    <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            len_q     <= req_len[win*8 +: 8];
            count     <= req_len[win*8 +: 8];
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            // The local count, not the slave's rlast, decides where the burst ends.
            if (m_axi_rlast != (count == 8'd0)) proto_q <= 1'b1;
            if (count == 8'd0) begin
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              count <= count - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// Randomised bench for axi_ram_rd_arbiter: an AXI RAM slave model plus a
// transaction-level reference model checked every cycle, and directed scenarios.
module tb_axi_ram_rd_arbiter;
  localparam int P  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [P-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [P*AW-1:0] req_addr;
  logic [P*8-1:0]  req_len;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last, rsp_err, proto_err;
  logic [IW-1:0]   arid, rid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, rresp;
  logic            arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0]   rdata;

  always #5 clk = ~clk;

  axi_ram_rd_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .proto_err(proto_err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Word-addressed RAM contents shared by the slave model and the reference model.
  logic [31:0] mem [16384];

  // Requesters: each port offers pend_n identical requests back to back.
  int          pend_n    [P];
  logic [15:0] pend_addr [P];
  logic [7:0]  pend_len  [P];

  always_comb begin
    for (int p = 0; p < P; p++) begin
      req_valid[p]          = (pend_n[p] != 0);
      req_addr[p*AW +: AW]  = pend_addr[p];
      req_len[p*8 +: 8]     = pend_len[p];
    end
  end

  // Slave behaviour knobs.
  int   rdy_mode   = 0;   // 0: always ready, 1: toggle 1-0-1-0, 2: random
  bit   rv_rand    = 1'b0;
  bit   ar_rand    = 1'b0;
  bit   err_mode   = 1'b0;
  int   early_idx  = -1;  // beat index on which the slave raises rlast instead of the true last
  int   stall_left = 0;
  bit   tog        = 1'b0;

  // Slave state.
  bit   s_active = 1'b0;
  int   s_base, s_len, s_k;

  // Handshakes observed at the falling edge, consumed after the next rising edge.
  bit          h_rst = 1'b1;
  logic [P-1:0] h_fire = '0;
  bit          h_ar = 1'b0, h_r = 1'b0;
  logic [AW-1:0] h_araddr;
  logic [7:0]  h_arlen;

  // Reference model: one transaction record plus round-robin pointer.
  bit m_busy = 1'b0, m_ar_done = 1'b0, m_proto = 1'b0;
  int m_port, m_addr, m_len, m_k, m_last = P - 1;
  int win_m, idx_m;
  logic [P-1:0] exp_rr, exp_rv;

  // Logs captured from the DUT for the directed literal checks.
  int          grant_log[$];
  int          ar_id_log[$], ar_addr_log[$], ar_len_log[$], ar_size_log[$], ar_burst_log[$];
  logic [31:0] bd_log[$];
  bit          bl_log[$];
  int          bp_log[$];
  int          rv1_seen = 0, stall_seen = 0, stall_rr_seen = 0;

  task automatic clear_logs();
    grant_log.delete(); ar_id_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
    ar_size_log.delete(); ar_burst_log.delete();
    bd_log.delete(); bl_log.delete(); bp_log.delete();
    rv1_seen = 0; stall_seen = 0; stall_rr_seen = 0;
  endtask

  // Slave model and back-pressure driver, one step after each rising edge.
  always @(posedge clk) begin
    #1;
    if (h_rst) begin
      s_active = 1'b0;
      s_k      = 0;
    end else begin
      for (int p = 0; p < P; p++)
        if (h_fire[p] && pend_n[p] > 0) pend_n[p]--;
      if (h_ar) begin
        s_active = 1'b1;
        s_base   = int'(h_araddr) >> 2;
        s_len    = int'(h_arlen);
        s_k      = 0;
      end else if (h_r && s_active) begin
        if (s_k == s_len) s_active = 1'b0;
        else s_k++;
      end
    end
    if (arvalid && stall_left > 0) begin
      arready = 1'b0;
      stall_left--;
    end else begin
      arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rvalid = s_active && (rv_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    rdata  = s_active ? mem[s_base + s_k] : $urandom;
    rresp  = (err_mode && (s_k % 3 == 1)) ? 2'b10 : 2'b00;
    rlast  = (early_idx >= 0) ? (s_k == early_idx) : (s_k == s_len);
    rid    = IW'($urandom);
    case (rdy_mode)
      0:       rsp_ready = '1;
      1:       begin tog = ~tog; rsp_ready = {P{tog}}; end
      default: rsp_ready = P'($urandom);
    endcase
  end

  // Compare process: checks every output against the model, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_ar_done = 1'b0; m_proto = 1'b0; m_k = 0; m_last = P - 1;
      h_rst = 1'b1; h_fire = '0; h_ar = 1'b0; h_r = 1'b0;
    end else begin
      h_rst  = 1'b0;
      win_m  = -1;
      exp_rr = '0;
      if (!m_busy)
        for (int i = 1; i <= P; i++) begin
          idx_m = (m_last + i) % P;
          if (win_m < 0 && req_valid[idx_m]) win_m = idx_m;
        end
      if (win_m >= 0) exp_rr[win_m] = 1'b1;
      exp_rv = '0;
      if (m_busy && m_ar_done && rvalid) exp_rv[m_port] = 1'b1;

      check("req_ready", req_ready, exp_rr);
      check("arvalid", arvalid, m_busy && !m_ar_done);
      check("rready", rready, m_busy && m_ar_done && rsp_ready[m_port]);
      check("rsp_valid", rsp_valid, exp_rv);
      check("proto_err", proto_err, m_proto);
      if (m_busy && !m_ar_done) begin
        check("araddr", araddr, m_addr);
        check("arlen", arlen, m_len);
        check("arid", arid, m_port);
        check("arsize", arsize, 2);
        check("arburst", arburst, 1);
      end
      if (exp_rv != '0) begin
        check("rsp_data", rsp_data, mem[(m_addr >> 2) + m_k]);
        check("rsp_last", rsp_last, m_k == m_len);
        check("rsp_err", rsp_err, err_mode && (m_k % 3 == 1));
      end

      if (rsp_valid[1]) rv1_seen++;
      if (arvalid && !arready) stall_seen++;
      if (arvalid && req_ready != '0) stall_rr_seen++;
      for (int p = 0; p < P; p++) if (req_valid[p] && req_ready[p]) grant_log.push_back(p);
      if (arvalid && arready) begin
        ar_id_log.push_back(int'(arid)); ar_addr_log.push_back(int'(araddr));
        ar_len_log.push_back(int'(arlen)); ar_size_log.push_back(int'(arsize));
        ar_burst_log.push_back(int'(arburst));
      end
      if (rvalid && rready)
        for (int p = 0; p < P; p++)
          if (rsp_valid[p]) begin
            bd_log.push_back(rsp_data); bl_log.push_back(rsp_last); bp_log.push_back(p);
          end

      h_fire = req_valid & req_ready;
      h_ar = arvalid && arready;
      h_r = rvalid && rready;
      h_araddr = araddr;
      h_arlen = arlen;

      if (m_busy && m_ar_done && rvalid && rsp_ready[m_port]) begin
        if (rlast != (m_k == m_len)) m_proto = 1'b1;
        if (m_k == m_len) begin
          m_busy = 1'b0;
          m_last = m_port;
        end else begin
          m_k++;
        end
      end else if (m_busy && !m_ar_done && arready) begin
        m_ar_done = 1'b1;
      end
      if (win_m >= 0) begin
        m_busy = 1'b1; m_ar_done = 1'b0; m_port = win_m;
        m_addr = int'(pend_addr[win_m]); m_len = int'(pend_len[win_m]); m_k = 0;
      end
    end
  end

  // Stimulus steps happen two time units after a rising edge, so the compare
  // process and the DUT always see the same inputs.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((m_busy || pend_n[0] != 0 || pend_n[1] != 0) && n < budget) begin
      step(1);
      n++;
    end
    check("drain_timeout", m_busy || pend_n[0] != 0 || pend_n[1] != 0, 0);
  endtask

  task automatic request(input int p, input int addr, input int len, input int n);
    pend_addr[p] = 16'(addr);
    pend_len[p]  = 8'(len);
    pend_n[p]    = n;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  logic [31:0] single_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  int          alt_exp    [4] = '{0, 1, 0, 1};
  int          lasts, budget;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[16'h40] = 32'h11; mem[16'h41] = 32'h22; mem[16'h42] = 32'h33; mem[16'h43] = 32'h44;
    for (int p = 0; p < P; p++) begin pend_n[p] = 0; pend_addr[p] = '0; pend_len[p] = '0; end
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    rsp_ready = '0;

    step(3);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_rsp_last", rsp_last, 1);
    check("reset_req_ready", req_ready, 0);
    check("reset_arvalid", arvalid, 0);
    check("reset_rready", rready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_proto_err", proto_err, 0);
    step(1);

    // Single request on port 0.
    clear_logs();
    request(0, 16'h0100, 3, 1);
    wait_done(200);
    check("single_ar_count", ar_addr_log.size(), 1);
    if (ar_addr_log.size() >= 1) begin
      check("single_araddr", ar_addr_log[0], 16'h0100);
      check("single_arlen", ar_len_log[0], 3);
      check("single_arsize", ar_size_log[0], 2);
      check("single_arburst", ar_burst_log[0], 1);
      check("single_arid", ar_id_log[0], 0);
    end
    check("single_beats", bd_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < bd_log.size()) begin
        check("single_data", bd_log[k], single_exp[k]);
        check("single_last", bl_log[k], k == 3);
        check("single_port", bp_log[k], 0);
      end
    check("single_rsp_valid1", rv1_seen, 0);

    // Fairness from reset: both ports hold requests of len 0.
    pulse_reset();
    step(1);
    clear_logs();
    request(0, 16'h0200, 0, 2);
    request(1, 16'h0300, 0, 2);
    wait_done(200);
    check("fair_grants", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size() && k < ar_id_log.size()) begin
        check("fair_grant_order", grant_log[k], alt_exp[k]);
        check("fair_arid", ar_id_log[k], alt_exp[k]);
      end

    // Back-pressure: port 1, len 7, rsp_ready toggling.
    clear_logs();
    rdy_mode = 1;
    request(1, 16'h0400, 7, 1);
    wait_done(300);
    check("bp_beats", bd_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < bd_log.size()) begin
        check("bp_data", bd_log[k], mem[16'h100 + k]);
        check("bp_port", bp_log[k], 1);
      end
    rdy_mode = 0;

    // AR stall with a competing request pending.
    clear_logs();
    stall_left = 5;
    request(0, 16'h0500, 1, 1);
    step(2);
    request(1, 16'h0520, 0, 1);
    wait_done(300);
    check("stall_cycles", stall_seen, 5);
    check("stall_req_ready", stall_rr_seen, 0);
    check("stall_grant_order", grant_log.size(), 2);

    // Early rlast from the slave.
    clear_logs();
    early_idx = 1;
    request(0, 16'h0600, 3, 1);
    wait_done(200);
    early_idx = -1;
    check("proto_set", proto_err, 1);
    check("proto_beats", bd_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < bl_log.size()) check("proto_last", bl_log[k], k == 3);
    request(1, 16'h0700, 2, 1);
    wait_done(200);
    check("proto_sticky", proto_err, 1);

    // Randomised traffic on both ports.
    rv_rand = 1'b1; ar_rand = 1'b1; err_mode = 1'b1; rdy_mode = 2;
    for (int round = 0; round < 40; round++) begin
      for (int p = 0; p < P; p++)
        if (pend_n[p] == 0 && $urandom_range(0, 1) == 1)
          request(p, $urandom_range(0, 15) * 4096 + $urandom_range(0, 63) * 4,
                  $urandom_range(0, 15), $urandom_range(1, 2));
      step($urandom_range(1, 20));
    end
    wait_done(5000);
    rv_rand = 1'b0; ar_rand = 1'b0; err_mode = 1'b0; rdy_mode = 0;

    // Reset during beat 2 of a len 7 burst.
    clear_logs();
    request(0, 16'h0800, 7, 1);
    budget = 0;
    while (!(m_busy && m_ar_done && m_k == 1) && budget < 100) begin step(1); budget++; end
    check("midrst_reach_beat2", m_k, 1);
    pulse_reset();
    @(negedge clk); #1;
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_proto_clear", proto_err, 0);
    step(1);
    clear_logs();
    request(0, 16'h0100, 2, 1);
    wait_done(200);
    check("after_rst_beats", bd_log.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < bd_log.size()) check("after_rst_data", bd_log[k], single_exp[k]);

    // Maximum burst length.
    clear_logs();
    request(0, 16'h0800, 255, 1);
    wait_done(1000);
    lasts = 0;
    foreach (bl_log[k]) if (bl_log[k]) lasts++;
    check("len255_beats", bd_log.size(), 256);
    check("len255_last_count", lasts, 1);
    if (bl_log.size() == 256) check("len255_last_pos", bl_log[255], 1);

    step(3);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_ram_rd_arbiter.md
# axi_ram_rd_arbiter

Round-robin read arbiter sharing the read channel of one AXI4 RAM slave (`axi_ram`) among PORTS simple requesters, such as layer-config and weight fetchers. Each requester issues an (address, length) burst request. The block turns the granted request into a single INCR AR transaction and routes the R beats back to that requester with a locally generated last flag. Exactly one burst is outstanding at a time.

## Interface

Parameters:
- PORTS, 2: number of requesters (≥2).
- DATA_WIDTH, 32: AXI data width.
- ADDR_WIDTH, 16: AXI byte-address width.
- STRB_WIDTH, DATA_WIDTH/8: bytes per beat; must be a power of two.
- ID_WIDTH, 8: AXI ID width; must satisfy ID_WIDTH ≥ $clog2(PORTS).

Ports:
- Reset is `rst`, synchronous, active-high; the clock is `clk`.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  PORTS  request valid, one bit per port.
- req_ready  out  PORTS  request accepted (one-hot pulse).
- req_addr  in  PORTS*ADDR_WIDTH  byte start address per port; must be beat-aligned.
- req_len  in  PORTS*8  beats minus 1 per port (AXI LEN encoding).
- rsp_data  out  DATA_WIDTH  read data, shared by all ports.
- rsp_valid  out  PORTS  data valid, one-hot to the granted port.
- rsp_ready  in  PORTS  per-port data ready.
- rsp_last  out  1  final beat of the burst, from the local counter.
- rsp_err  out  1  rresp of the current beat is nonzero.
- proto_err  out  1  sticky: R rlast did not match the local beat count.
- m_axi_arid  out  ID_WIDTH  granted port index, zero-extended.
- m_axi_araddr  out  ADDR_WIDTH.
- m_axi_arlen  out  8.
- m_axi_arsize  out  3  constant $clog2(STRB_WIDTH).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1.
- m_axi_arready  in  1.
- m_axi_rid  in  ID_WIDTH  ignored.
- m_axi_rdata  in  DATA_WIDTH.
- m_axi_rresp  in  2.
- m_axi_rlast  in  1.
- m_axi_rvalid  in  1.
- m_axi_rready  out  1.

## Operation

- FSM states: IDLE, ADDR, DATA.
- **IDLE:**
  - Search order starts at last_grant+1 (mod PORTS); the first port with req_valid high wins.
  - req_ready[win] is asserted combinationally in that same cycle.
  - The block registers grant=win, addr, len and count=len, then goes to ADDR.
  - All other req_ready bits are 0. No request means stay in IDLE.
- **ADDR:**
  - m_axi_arvalid=1; araddr, arlen and arid come from registers and are held stable until the handshake.
  - On arready: go to DATA.
- **DATA:**
  - rsp_valid[grant] = m_axi_rvalid.
  - m_axi_rready = rsp_ready[grant].
  - rsp_data = m_axi_rdata; rsp_err = (m_axi_rresp != 0).
  - rsp_last = (count == 0).
  - On each beat (rvalid & rready): count decrements by 1. If m_axi_rlast != (count == 0), proto_err is set.
  - Last beat (count==0 and the beat handshakes): last_grant←grant, go to IDLE.
  - A slave that asserts rlast early leaves the burst to finish by count. Beats after the last are not accepted because rready=0 outside DATA.
- Requesters must not cross a 4 KB boundary; the block does not split bursts.
- Non-granted rsp_valid bits are always 0. rsp_ready of non-granted ports is ignored.
- The request payload is sampled only in the req_ready cycle. req_valid may drop while the port is not granted.

## Timing

- Reset values:
  - state=IDLE, last_grant=PORTS-1 (port 0 has first priority), count=0, proto_err=0.
  - m_axi_arvalid=0, m_axi_rready=0, rsp_valid=0, req_ready=0 (with req_valid low), rsp_last=1 (count 0, but qualified by rsp_valid=0).
- The request handshake is cycle 0. m_axi_arvalid rises in cycle 1.
- The earliest first R beat depends on the slave. The data path is combinational, with zero added latency.
- After the last beat, the next req_ready can fire in the following cycle. Minimum gap between AR handshakes: 2 cycles plus the burst length.
- Reset mid-burst returns to IDLE at the next edge and drops arvalid/rready. The RAM shares rst, so it also abandons the burst. proto_err clears only on rst.
- len=0 gives a single beat with rsp_last=1 on that beat.
- len=255 gives 256 beats, with rsp_last only on the 256th.

## Test plan

- **Single request:** port 0 requests addr 0x0100, len 3; RAM is preloaded with 0x11..0x44.
  - AR shows addr 0x0100, len 3, size 2, burst INCR, id 0.
  - Port 0 gets four beats 0x11, 0x22, 0x33, 0x44, with rsp_last only on the 4th.
  - rsp_valid[1] stays 0.
- **Fairness:** both ports hold req_valid continuously with len 0.
  - Grants alternate 0,1,0,1 starting at port 0 after reset.
  - arid alternates 0,1.
- **Back-pressure:** port 1 burst of len 7 with rsp_ready toggled 1-0-1-0.
  - All 8 beats are delivered in order, none dropped or duplicated.
  - m_axi_rready mirrors rsp_ready[1].
- **AR stall:** arready is held low for 5 cycles.
  - araddr, arlen and arid stay stable.
  - No second req_ready during the stall.
- **Protocol error:** the slave model asserts rlast on beat 2 of a len 3 burst.
  - proto_err becomes 1 and stays 1.
  - rsp_last still appears on beat 4.
- **Reset mid-burst:** rst is pulsed during beat 2 of a len 7 burst.
  - Next cycle: state IDLE, arvalid=0, rready=0.
  - A new port 0 request then completes normally.
